// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the mult/div sequencing controller.
// State encoding is exported on state_dbg; the HI/LO select constants are
// shared with the HI/LO input muxes so both sides agree on polarity.
package multdiv_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_MULT_RUN  = 3'd1,
        ST_DIV_RUN   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_DIV0      = 3'd4
    } state_e;

    localparam logic HILO_SEL_DIV  = 1'b0;
    localparam logic HILO_SEL_MULT = 1'b1;

    // True while a unit is running and the timeout counter should advance.
    function automatic logic is_run(input state_e s);
        return (s == ST_MULT_RUN) || (s == ST_DIV_RUN);
    endfunction

endpackage

// File: rtl/multdiv_timer.sv
// Per-operation cycle counter for the mult/div controller.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_clear     - force count to zero (has priority over i_enable)
//   i_enable    - advance count by one
//   o_count     - current count
//   o_expired   - count has reached TIMEOUT-1
module multdiv_timer #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_count;

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the multi-cycle multiplier and divider that
// feed HI/LO: launches the selected unit, waits for its done, then drives
// the HI/LO select and write enables. Flags divide-by-zero and timeouts,
// and stalls MFHI/MFLO while a result is pending.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   mult_start, div_start      - issue requests (honoured in IDLE only)
//   div_divisor                - divisor, checked for zero on div issue
//   mult_done, div_done        - unit result-valid pulses
//   hilo_read_req              - MFHI/MFLO executing this cycle
//   mult_go, div_go            - one-cycle launch pulses
//   hilo_sel                   - HI/LO mux select (0 div, 1 mult)
//   hi_write, lo_write         - HI/LO write enables
//   busy, stall                - not idle / hold control FSM
//   div_zero, timeout          - one-cycle exception pulses
//   state_dbg                  - current state encoding
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] div_divisor,
    input  logic        mult_done,
    input  logic        div_done,
    input  logic        hilo_read_req,
    output logic        mult_go,
    output logic        div_go,
    output logic        hilo_sel,
    output logic        hi_write,
    output logic        lo_write,
    output logic        busy,
    output logic        stall,
    output logic        div_zero,
    output logic        timeout,
    output logic [2:0]  state_dbg
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e           r_state;
    state_e           w_state_next;
    logic             r_hilo_sel;
    logic             w_hilo_sel_next;
    logic             r_timeout;
    logic             w_timeout_next;
    logic             w_in_run;
    logic             w_first_run;
    logic [CNT_W-1:0] w_count;
    logic             w_expired;

    assign w_in_run = is_run(r_state);

    // Counter is held at zero outside RUN, so it reads zero on RUN entry.
    multdiv_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (!w_in_run),
        .i_enable  (w_in_run),
        .o_count   (w_count),
        .o_expired (w_expired)
    );

    // The counter never wraps back to zero within a run, so zero marks the
    // first RUN cycle.
    assign w_first_run = (w_count == '0);

    // State and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hilo_sel <= HILO_SEL_DIV;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_hilo_sel <= w_hilo_sel_next;
            r_timeout  <= w_timeout_next;
        end
    end

    // Next-state logic; done wins over a coincident timeout.
    always_comb begin
        w_state_next    = r_state;
        w_hilo_sel_next = r_hilo_sel;
        w_timeout_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mult_start) begin
                    w_state_next    = ST_MULT_RUN;
                    w_hilo_sel_next = HILO_SEL_MULT;
                end else if (div_start) begin
                    if (div_divisor == 32'd0) begin
                        w_state_next = ST_DIV0;
                    end else begin
                        w_state_next    = ST_DIV_RUN;
                        w_hilo_sel_next = HILO_SEL_DIV;
                    end
                end
            end
            ST_MULT_RUN: begin
                if (mult_done) begin
                    w_state_next = ST_WRITEBACK;
                end else if (w_expired) begin
                    w_state_next   = ST_IDLE;
                    w_timeout_next = 1'b1;
                end
            end
            ST_DIV_RUN: begin
                if (div_done) begin
                    w_state_next = ST_WRITEBACK;
                end else if (w_expired) begin
                    w_state_next   = ST_IDLE;
                    w_timeout_next = 1'b1;
                end
            end
            ST_WRITEBACK: w_state_next = ST_IDLE;
            ST_DIV0:      w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only (stall also uses the request).
    assign mult_go   = (r_state == ST_MULT_RUN) && w_first_run;
    assign div_go    = (r_state == ST_DIV_RUN) && w_first_run;
    assign hilo_sel  = r_hilo_sel;
    assign hi_write  = (r_state == ST_WRITEBACK);
    assign lo_write  = (r_state == ST_WRITEBACK);
    assign busy      = (r_state != ST_IDLE);
    assign stall     = hilo_read_req && busy;
    assign div_zero  = (r_state == ST_DIV0);
    assign timeout   = r_timeout;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: a driver issues transactions and pushes the
// expected output events (kind, cycle, hilo_sel) into a queue; a monitor
// pops and compares whenever the DUT shows a pulse or write, and checks
// busy/stall every cycle against the expected busy window.
module tb_multdiv_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] div_divisor = 32'd0;
    logic        mult_done = 1'b0;
    logic        div_done = 1'b0;
    logic        hilo_read_req = 1'b0;
    logic        mult_go, div_go, hilo_sel, hi_write, lo_write;
    logic        busy, stall, div_zero, timeout;
    logic [2:0]  state_dbg;

    multdiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .mult_start    (mult_start),
        .div_start     (div_start),
        .div_divisor   (div_divisor),
        .mult_done     (mult_done),
        .div_done      (div_done),
        .hilo_read_req (hilo_read_req),
        .mult_go       (mult_go),
        .div_go        (div_go),
        .hilo_sel      (hilo_sel),
        .hi_write      (hi_write),
        .lo_write      (lo_write),
        .busy          (busy),
        .stall         (stall),
        .div_zero      (div_zero),
        .timeout       (timeout),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_MGO, EV_DGO, EV_WB, EV_DIV0, EV_TMO} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cyc;
        logic     sel;
    } ev_t;

    ev_t  exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    int   busy_lo  = 1;
    int   busy_hi  = 0;
    logic mdl_sel  = 1'b0;   // HI/LO select the model believes is current
    bit   rr_hold  = 1'b0;

    function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endfunction

    function void expect_ev(input ev_kind_e k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.sel  = mdl_sel;
        exp_q.push_back(e);
    endfunction

    function void got_ev(input ev_kind_e k);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL event: unexpected kind %0d at cyc %0d, expected none", k, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k && e.cyc == cyc && e.sel === hilo_sel) n_pass++;
            else $display("FAIL event: got kind %0d cyc %0d sel %0b expected kind %0d cyc %0d sel %0b",
                          k, cyc, hilo_sel, e.kind, e.cyc, e.sel);
        end
    endfunction

    // Monitor: compare every cycle on the falling edge.
    always @(negedge clk) begin
        bit eb;
        if (mon_en) begin
            eb = (cyc >= busy_lo) && (cyc <= busy_hi);
            check("busy", 32'(busy), 32'(eb));
            check("stall", 32'(stall), 32'(hilo_read_req && eb));
            if (mult_go)  got_ev(EV_MGO);
            if (div_go)   got_ev(EV_DGO);
            if (hi_write || lo_write) begin
                check("hi_lo_pair", 32'({hi_write, lo_write}), 32'(2'b11));
                got_ev(EV_WB);
            end
            if (div_zero) got_ev(EV_DIV0);
            if (timeout)  got_ev(EV_TMO);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rr();
        hilo_read_req = rr_hold ? 1'b1 : 1'($urandom());
    endtask

    // One transaction. d = RUN cycles before the matching done is driven;
    // d >= TIMEOUT withholds done entirely.
    task automatic run_txn(input bit do_mult, input bit do_div, input logic [31:0] dvsr, input int d);
        int  k;
        int  end_c;
        bit  tmo;
        mult_start  = do_mult;
        div_start   = do_div;
        div_divisor = dvsr;
        mult_done   = 1'b0;
        div_done    = 1'b0;
        set_rr();
        tick();
        k = cyc;
        mult_start  = 1'b0;
        div_start   = 1'b0;
        div_divisor = $urandom();
        tmo = 1'b0;
        if (do_mult || dvsr != 32'd0) begin
            mdl_sel = do_mult;
            expect_ev(do_mult ? EV_MGO : EV_DGO, k);
            if (d <= TIMEOUT - 1) begin
                end_c = k + 1 + d;
                expect_ev(EV_WB, end_c);
                busy_hi = end_c;
            end else begin
                tmo = 1'b1;
                end_c = k + TIMEOUT;
                expect_ev(EV_TMO, end_c);
                busy_hi = k + TIMEOUT - 1;
            end
            busy_lo = k;
            for (int j = 0; j < TIMEOUT; j++) begin
                // Non-matching done and late starts are noise the DUT must ignore.
                mult_start = 1'($urandom());
                div_start  = 1'($urandom());
                if (do_mult) begin
                    mult_done = (j == d);
                    div_done  = 1'($urandom());
                end else begin
                    div_done  = (j == d);
                    mult_done = 1'($urandom());
                end
                set_rr();
                tick();
                if (j == d) break;
            end
        end else begin
            expect_ev(EV_DIV0, k);
            busy_lo = k;
            busy_hi = k;
        end
        if (!tmo) begin
            // WRITEBACK or DIV0 cycle: starts and dones here are ignored.
            mult_start = 1'($urandom());
            div_start  = 1'($urandom());
            mult_done  = 1'($urandom());
            div_done   = 1'($urandom());
            set_rr();
            tick();
        end
        mult_start = 1'b0;
        div_start  = 1'b0;
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            mult_done = 1'($urandom());
            div_done  = 1'($urandom());
            set_rr();
            tick();
        end
        mult_done = 1'b0;
        div_done  = 1'b0;
    endtask

    // Launch, run 10 RUN cycles, then reset with the counter at 10.
    task automatic reset_mid(input bit do_mult);
        int k;
        mult_start  = do_mult;
        div_start   = !do_mult;
        div_divisor = 32'd9;
        tick();
        k = cyc;
        mult_start = 1'b0;
        div_start  = 1'b0;
        mdl_sel = do_mult;
        expect_ev(do_mult ? EV_MGO : EV_DGO, k);
        busy_lo = k;
        busy_hi = k + 10;
        for (int j = 0; j < 10; j++) begin
            set_rr();
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_sel = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hilo_sel", 32'(hilo_sel), 32'd0);
        check("rst_writes", 32'({hi_write, lo_write}), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_pending", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        int op;
        int r;
        int d;
        reset = 1'b1;
        tick();
        tick();
        check("init_state", 32'(state_dbg), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        check("init_hilo_sel", 32'(hilo_sel), 32'd0);
        check("init_pulses", 32'({mult_go, div_go, hi_write, lo_write, div_zero, timeout}), 32'd0);
        mon_en = 1'b1;
        reset  = 1'b0;
        tick();

        // Normal mult, done after 32 cycles, MFHI/MFLO request held throughout.
        rr_hold = 1'b1;
        run_txn(1'b1, 1'b0, 32'd0, 31);
        rr_hold = 1'b0;
        check("sel_holds_in_idle", 32'(hilo_sel), 32'd1);

        // Divide by zero, then a normal divide.
        run_txn(1'b0, 1'b1, 32'd0, 0);
        check("div0_keeps_sel", 32'(hilo_sel), 32'd1);
        run_txn(1'b0, 1'b1, 32'd7, 5);

        // Both starts: mult wins.
        run_txn(1'b1, 1'b1, 32'd3, 10);

        // Minimum latency and done coinciding with timeout.
        run_txn(1'b0, 1'b1, 32'd11, 0);
        run_txn(1'b1, 1'b0, 32'd0, TIMEOUT - 1);

        // Timeout with done withheld.
        run_txn(1'b0, 1'b1, 32'd5, 1000);

        // Reset mid-operation.
        reset_mid(1'b0);
        run_txn(1'b1, 1'b0, 32'd0, 2);
        reset_mid(1'b1);

        // Randomised traffic.
        for (int t = 0; t < 60; t++) begin
            op = int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 9));
            if (r == 0)      d = TIMEOUT + 5;
            else if (r == 1) d = TIMEOUT - 1;
            else             d = int'($urandom_range(0, 20));
            case (op)
                0: run_txn(1'b1, 1'b0, $urandom(), d);
                1: run_txn(1'b0, 1'b1, $urandom() | 32'd1, d);
                2: run_txn(1'b0, 1'b1, 32'd0, d);
                default: run_txn(1'b1, 1'b1, $urandom(), d);
            endcase
        end

        tick();
        tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencing controller for the multi-cycle multiplier and divider that feed the HI/LO registers.
- Accepts MULT/DIV issue from the main control unit and launches the selected unit.
- Waits for that unit's done, then drives the HI/LO source select and the HI/LO write enables.
- Detects divide-by-zero and per-operation timeout.
- Stalls MFHI/MFLO while a result is pending.
- Sits between the control FSM and the mult/div units plus the HI/LO input muxes.

Parameters:
TIMEOUT, 40, max cycles in a RUN state before abort (must be > worst-case unit latency, 32 + margin)
CNT_W, $clog2(TIMEOUT+1), cycle counter width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
mult_start  in  1  control unit issues MULT/MULTU (sampled in IDLE only)
div_start  in  1  control unit issues DIV/DIVU (sampled in IDLE only)
div_divisor  in  32  divisor operand, checked for zero when div_start is accepted
mult_done  in  1  multiplier result valid (1-cycle pulse)
div_done  in  1  divider result valid (1-cycle pulse)
hilo_read_req  in  1  control unit is executing MFHI/MFLO this cycle
mult_go  out  1  1-cycle launch pulse to multiplier
div_go  out  1  1-cycle launch pulse to divider
hilo_sel  out  1  HI/LO mux select: 0 = divider, 1 = multiplier
hi_write  out  1  HI register write enable
lo_write  out  1  LO register write enable
busy  out  1  high in any state other than IDLE
stall  out  1  hold control FSM (MFHI/MFLO hazard)
div_zero  out  1  1-cycle exception pulse, divisor == 0
timeout  out  1  1-cycle pulse, unit failed to report done
state_dbg  out  3  current state encoding, for debug/bench

Behaviour:
- Reset (sync, highest priority, any state): state = IDLE, counter = 0, hilo_sel = 0. All pulse outputs, hi_write, lo_write, busy and stall = 0.
- States: IDLE, MULT_RUN, DIV_RUN, WRITEBACK, DIV0.
- IDLE:
  - mult_start = 1 → MULT_RUN. mult_start has priority when both starts are high; div_start is dropped in that case.
  - Else div_start = 1 with div_divisor == 0 → DIV0.
  - Else div_start = 1 → DIV_RUN.
  - Starts arriving in any state other than IDLE are ignored.
- Launch:
  - hilo_sel is registered on the IDLE→RUN edge: 1 for mult, 0 for div.
  - hilo_sel holds its value until the next launch, including through IDLE.
  - mult_go / div_go are high only during the first cycle in the corresponding RUN state.
  - The counter clears on entry to RUN.
- MULT_RUN / DIV_RUN:
  - Counter increments each cycle.
  - The matching done → WRITEBACK. The non-matching done is ignored.
  - Counter == TIMEOUT-1 with no done → IDLE, timeout = 1 in the first IDLE cycle, no writes.
  - If done and timeout coincide, done wins.
- WRITEBACK: exactly 1 cycle. hi_write = lo_write = 1, hilo_sel held. Then → IDLE.
- DIV0: exactly 1 cycle. div_zero = 1, no go, no writes, hilo_sel unchanged. Then → IDLE.
- Latency: start sampled at edge N; go at cycle N+1; done sampled at edge M; writes in cycle M+1; IDLE at M+2. Minimum total is 3 cycles, with done in the first RUN cycle.
- busy = (state != IDLE).
- stall = hilo_read_req && busy. This includes WRITEBACK, because HI/LO update at the end of that cycle.
- done pulses received in IDLE, WRITEBACK or DIV0 are ignored.
- All outputs are combinationally decoded from registered state/flags only. There are no combinational paths from inputs to outputs, except stall (hilo_read_req AND busy).

Decomposition:
- Shared package: state encoding constants (IDLE=0, MULT_RUN=1, DIV_RUN=2, WRITEBACK=3, DIV0=4) and HILO_SEL_DIV=0 / HILO_SEL_MULT=1. The HI/LO muxes use the same select constants.
- One natural sub-module, multdiv_timer: a counter with clear, enable and expired output, parameterised by TIMEOUT.

Test Plan:
- Reset mid-operation: reset during DIV_RUN at counter = 10 → next cycle IDLE, busy = 0, hilo_sel = 0, no writes.
- Normal mult: mult_start in IDLE, mult_done after 32 cycles → mult_go for 1 cycle, hilo_sel = 1, hi_write = lo_write = 1 for exactly 1 cycle, then IDLE.
- Div by zero: div_start, div_divisor = 0 → DIV0 for 1 cycle, div_zero = 1, div_go = 0, no writes. Then div_divisor = 7 → DIV_RUN with div_go, hilo_sel = 0.
- Simultaneous starts: mult_start = div_start = 1 → MULT_RUN, div_go never asserted. div_done injected during MULT_RUN → ignored.
- Timeout: div_start with divisor = 5, div_done withheld → after TIMEOUT = 40 RUN cycles returns to IDLE, timeout pulses once, hi_write and lo_write stay 0.
- Stall hazard: hilo_read_req held through a mult → stall = 1 for every RUN and WRITEBACK cycle, 0 in the cycle after WRITEBACK.
